// File: rtl/seg7_frame_scanner.sv
// ---------------------------------------------------------------------------
// seg7_frame_scanner
//
// Display back end for a multiplexed seven-segment display. A complete frame
// of per-digit segment patterns is accepted over a valid/ready handshake into
// a shadow buffer. The shadow is copied into the active buffer only on the
// last cycle of a full scan, so a frame is never shown partially. Each digit
// slot starts with a few dark cycles to suppress ghosting between digits.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   frame_data   8*w_digit segment patterns, digit i in bits [8i+7:8i],
//                order abcdefgh (MSB = a, LSB = h/dp)
//   frame_valid  frame_data holds a frame
//   frame_ready  shadow buffer is empty, a frame can be accepted
//   digit_en     per-digit enable, sampled every cycle
//   abcdefgh     segment drive, active-high
//   digit        one-hot digit select, active-high, bit 0 = rightmost
//   scan_wrap    one-cycle pulse on the last cycle of a full scan
// ---------------------------------------------------------------------------
module seg7_frame_scanner #(
  parameter int clk_mhz        = 50,
  parameter int w_digit        = 8,
  parameter int digit_rate_khz = 1,
  parameter int blank_cycles   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*w_digit-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [w_digit-1:0]   digit_en,
  output logic [7:0]           abcdefgh,
  output logic [w_digit-1:0]   digit,
  output logic                 scan_wrap
);

  localparam int DWELL = clk_mhz * 1000 / digit_rate_khz;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(w_digit - 1);
  localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(blank_cycles);
  localparam logic [w_digit-1:0] DIGIT_ONE = w_digit'(1);

  // Reject parameter sets that would leave no visible part of a slot.
  if (DWELL < 1 || blank_cycles < 0 || blank_cycles >= DWELL) begin : g_bad_params
    $error("seg7_frame_scanner: need 0 <= blank_cycles < DWELL");
  end

  // Storage
  logic [8*w_digit-1:0] active_q, active_d;
  logic [8*w_digit-1:0] shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Registered outputs
  logic [7:0]           abcdefgh_q, abcdefgh_d;
  logic [w_digit-1:0]   digit_q, digit_d;
  logic                 scan_wrap_q, scan_wrap_d;
  logic                 frame_ready_q, frame_ready_d;

  logic                 wrap_now;
  logic                 show;

  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    abcdefgh_d    = 8'h00;
    digit_d       = '0;
    scan_wrap_d   = 1'b0;
    frame_ready_d = 1'b1;
    wrap_now      = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    show          = 1'b0;

    // Slot timing: cnt runs through one slot, idx steps once per slot.
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Swap and capture are mutually exclusive: capture needs an empty
    // shadow, swap needs a full one. A frame captured on the wrap cycle
    // itself therefore waits for the following wrap.
    if (wrap_now && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end else if (frame_valid && frame_ready_q) begin
      shadow_d      = frame_data;
      shadow_full_d = 1'b1;
    end

    frame_ready_d = ~shadow_full_d;

    // Outputs are computed from next-state values so the registered
    // outputs line up with idx_q/cnt_q in the cycle they are visible.
    scan_wrap_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    show        = (cnt_d >= BLANK_END);
    if (show && digit_en[idx_d]) begin
      digit_d    = DIGIT_ONE << idx_d;
      abcdefgh_d = active_d[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      abcdefgh_q    <= 8'h00;
      digit_q       <= '0;
      scan_wrap_q   <= 1'b0;
      frame_ready_q <= 1'b1;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      abcdefgh_q    <= abcdefgh_d;
      digit_q       <= digit_d;
      scan_wrap_q   <= scan_wrap_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign abcdefgh    = abcdefgh_q;
  assign digit       = digit_q;
  assign scan_wrap   = scan_wrap_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_seg7_frame_scanner.sv
// ---------------------------------------------------------------------------
// Bench for seg7_frame_scanner with 4 digits, 4-cycle slots and one blank
// cycle per slot (16-cycle scan). The driver steps one cycle at a time,
// pushes the expected outputs of that cycle into a scoreboard queue and
// advances a frame-level model; an independent monitor pops and compares on
// every falling edge and also checks outputs right after any reset assertion.
// ---------------------------------------------------------------------------
module tb_seg7_frame_scanner;

  localparam int ND   = 4;
  localparam int DW   = 4;
  localparam int BL   = 1;
  localparam int SCAN = ND * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   frame_data = 32'h0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [3:0]    digit_en = 4'hF;
  logic [7:0]    abcdefgh;
  logic [3:0]    digit;
  logic          scan_wrap;

  seg7_frame_scanner #(
    .clk_mhz       (1),
    .w_digit       (ND),
    .digit_rate_khz(250),
    .blank_cycles  (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .digit_en   (digit_en),
    .abcdefgh   (abcdefgh),
    .digit      (digit),
    .scan_wrap  (scan_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model
  int          t;
  logic [31:0] m_active;
  logic [31:0] m_pend;
  bit          m_pending;
  int          m_swap_at;
  logic [3:0]  m_en_prev;
  logic [3:0]  rnd_en;

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare scoreboard entries mid-cycle; after a reset assertion
  // check that the outputs dropped to their reset values before any edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("rst_seg",   -1, 32'(abcdefgh),    32'h0);
        chk("rst_digit", -1, 32'(digit),       32'h0);
        chk("rst_wrap",  -1, 32'(scan_wrap),   32'h0);
        chk("rst_ready", -1, 32'(frame_ready), 32'h1);
      end else if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("seg",         e.cyc, 32'(abcdefgh),    32'(e.seg));
        chk("digit",       e.cyc, 32'(digit),       32'(e.dig));
        chk("scan_wrap",   e.cyc, 32'(scan_wrap),   32'(e.wrap));
        chk("frame_ready", e.cyc, 32'(frame_ready), 32'(e.rdy));
      end
    end
  end

  task automatic model_reset();
    t         = 0;
    m_active  = 32'h0;
    m_pend    = 32'h0;
    m_pending = 1'b0;
    m_swap_at = 0;
    m_en_prev = digit_en;
  endtask

  // Called just after a rising edge: drive the inputs of cycle t and queue
  // what the display must show during cycle t.
  task automatic cyc_begin(input logic v, input logic [31:0] d, input logic [3:0] en);
    exp_t e;
    int   idx;
    int   cnt;
    bit   lit;
    frame_valid = v;
    frame_data  = d;
    digit_en    = en;
    idx   = (t / DW) % ND;
    cnt   = t % DW;
    lit   = (cnt >= BL) && m_en_prev[idx];
    e.cyc  = t;
    e.dig  = lit ? 4'(1 << idx) : 4'h0;
    e.seg  = lit ? m_active[idx*8 +: 8] : 8'h00;
    e.wrap = (t % SCAN) == SCAN - 1;
    e.rdy  = !m_pending;
    sb_q.push_back(e);
  endtask

  // Apply the rising edge that ends cycle t to the model, then advance.
  task automatic cyc_end();
    if (m_pending && t == m_swap_at) begin
      m_active  = m_pend;
      m_pending = 1'b0;
    end else if (!m_pending && frame_valid) begin
      m_pend    = frame_data;
      m_pending = 1'b1;
      // Swap happens on the first scan-end cycle strictly after capture.
      m_swap_at = (t / SCAN) * SCAN + SCAN - 1;
      if (m_swap_at <= t) m_swap_at += SCAN;
    end
    m_en_prev = digit_en;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] en);
    cyc_begin(v, d, en);
    cyc_end();
  endtask

  task automatic reset_dut();
    frame_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : driver
    // Idle scan, one frame at cycle 5, then half the digits disabled.
    reset_dut();
    for (int c = 0; c < 80; c++)
      step(c == 5, (c == 5) ? 32'hEEBCCE8E : $urandom, (c >= 32) ? 4'b0101 : 4'hF);

    // Frame A at cycle 5, frame B held valid from cycle 6 until taken.
    reset_dut();
    for (int c = 0; c < 64; c++) begin
      if (c == 5)                  step(1'b1, 32'h12345678, 4'hF);
      else if (c >= 6 && c <= 16)  step(1'b1, 32'hFFFFFFFF, 4'hF);
      else                         step(1'b0, $urandom, 4'hF);
    end

    // Frame offered exactly on the wrap cycle with an empty shadow.
    reset_dut();
    for (int c = 0; c < 56; c++)
      step(c == 15, (c == 15) ? 32'h7F065B4F : $urandom, 4'hF);

    // Asynchronous reset in the middle of slot 2 while a frame is pending.
    reset_dut();
    for (int c = 0; c < 42; c++) begin
      if (c == 5)       step(1'b1, 32'h6D7D077F, 4'hF);
      else if (c == 36) step(1'b1, 32'h3F063F06, 4'hF);
      else              step(1'b0, 32'h0, 4'hF);
    end
    cyc_begin(1'b0, 32'h0, 4'hF);
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 48; c++) step(1'b0, $urandom, 4'hF);

    // Randomized traffic and enable changes.
    reset_dut();
    rnd_en = 4'hF;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) rnd_en = 4'($urandom);
      step($urandom_range(0, 3) == 0, $urandom, rnd_en);
    end

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
